// File: rtl/uart_tx.sv
// uart_tx: serialises AXI-Stream bytes into 8N1/8N2 UART frames, LSB first.
// Line output is registered so the start bit appears on the accept edge.
module uart_tx #(
  parameter int NCLKS_PER_BIT = 217,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axis_in_tvalid,
  output logic       axis_in_tready,
  input  logic [7:0] axis_in_tdata,
  output logic       tx_data,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CW = $clog2(NCLKS_PER_BIT);

  if (NCLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $fatal(1, "uart_tx: NCLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end        = cnt_q == CW'(NCLKS_PER_BIT - 1);
  assign axis_in_tready = rst_n && state_q == IDLE;
  assign tx_data        = tx_q;
  assign tx_busy        = state_q != IDLE;
  assign tx_done        = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (axis_in_tvalid && axis_in_tready) begin
        state_d = START;
        shift_d = axis_in_tdata;
        tx_d    = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        state_d = (bit_q == 3'd7) ? STOP : DATA;
        bit_d   = bit_q + 1'b1;
        shift_d = shift_q >> 1;
        tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        stop_d  = 1'b0;
      end
      STOP: if (bit_end) begin
        state_d = (stop_q == 1'(STOP_BITS - 1)) ? IDLE : STOP;
        done_d  = stop_q == 1'(STOP_BITS - 1);
        stop_d  = stop_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame table plus multi-cycle corner sequences for uart_tx.
// A behavioural UART receiver per instance recovers bytes from the serial line.
module tb_uart_tx;
  localparam int N  = 217;
  localparam int N2 = 4;

  logic clk, rst_n;
  logic tvalid, tready, tx_data, busy, done;
  logic [7:0] tdata;
  logic tvalid2, tready2, tx_data2, busy2, done2;
  logic [7:0] tdata2;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;

  uart_tx #(.NCLKS_PER_BIT(N), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .axis_in_tvalid(tvalid), .axis_in_tready(tready),
    .axis_in_tdata(tdata), .tx_data(tx_data), .tx_busy(busy), .tx_done(done));

  uart_tx #(.NCLKS_PER_BIT(N2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .axis_in_tvalid(tvalid2), .axis_in_tready(tready2),
    .axis_in_tdata(tdata2), .tx_data(tx_data2), .tx_busy(busy2), .tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receivers: start detected on the first low sample, then bit-centre sampling.
  logic       rx_act = 1'b0, rx2_act = 1'b0;
  int         rx_cnt = 0, rx2_cnt = 0, rx_n = 0, rx2_n = 0;
  logic [7:0] rx_sh = '0, rx2_sh = '0;
  logic [8:0] rx_mem [0:511];
  logic [8:0] rx2_mem [0:511];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rx_act <= 1'b0;
    else if (!rx_act) begin
      if (!tx_data) begin rx_act <= 1'b1; rx_cnt <= 1; end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % N == N / 2) begin
        if (rx_cnt / N >= 1 && rx_cnt / N <= 8) rx_sh[rx_cnt / N - 1] <= tx_data;
        if (rx_cnt / N == 9) begin
          rx_mem[rx_n] <= {tx_data, rx_sh};
          rx_n <= rx_n + 1;
          rx_act <= 1'b0;
        end
      end
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rx2_act <= 1'b0;
    else if (!rx2_act) begin
      if (!tx_data2) begin rx2_act <= 1'b1; rx2_cnt <= 1; end
    end else begin
      rx2_cnt <= rx2_cnt + 1;
      if (rx2_cnt % N2 == N2 / 2) begin
        if (rx2_cnt / N2 >= 1 && rx2_cnt / N2 <= 8) rx2_sh[rx2_cnt / N2 - 1] <= tx_data2;
        if (rx2_cnt / N2 == 9) begin
          rx2_mem[rx2_n] <= {tx_data2, rx2_sh};
          rx2_n <= rx2_n + 1;
          rx2_act <= 1'b0;
        end
      end
    end

  typedef struct {
    logic [7:0] d;
    logic [7:0] alt;
    logic [9:0] line;
  } vec_t;
  vec_t v [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while (!tready && w < 5 * N) begin
      @(negedge clk);
      w++;
    end
    if (!tready) chk({nm, "_ready_timeout"}, 32'(tready), 32'd1);
  endtask

  // Sends one byte, swaps tdata to alt mid-frame, checks line at bit centres.
  task automatic run_frame(input vec_t t, input string nm);
    int done_k, done_n, bad;
    wait_ready(nm);
    tvalid = 1'b1;
    tdata  = t.d;
    @(posedge clk); #1;
    chk({nm, "_accept_line"}, 32'(tx_data), 32'd0);
    chk({nm, "_accept_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    tvalid = 1'b0;
    tdata  = t.alt;
    done_k = -1; done_n = 0; bad = 0;
    for (int k = 1; k <= 10 * N + 3; k++) begin
      @(posedge clk); #1;
      if (k % N == N / 2 && k < 10 * N)
        chk($sformatf("%s_bit%0d", nm, k / N), 32'(tx_data), 32'(t.line[k / N]));
      if (done) begin done_n++; done_k = k; end
      if (k < 10 * N && (tready || !busy)) bad++;
    end
    chk({nm, "_done_count"}, 32'(done_n), 32'd1);
    chk({nm, "_done_cycle"}, 32'(done_k), 32'(10 * N));
    chk({nm, "_ready_low_in_frame"}, 32'(bad), 32'd0);
    chk({nm, "_rx_byte"}, 32'(rx_mem[rx_n - 1]), 32'({1'b1, t.line[8:1]}));
  endtask

  initial begin
    int bad, dn, kd, ka, n0, w;
    logic pb;
    logic [7:0] b [256];
    int acc [256];
    v[0] = '{8'hA5, 8'hA5, 10'b1_10100101_0};
    v[1] = '{8'h00, 8'h00, 10'b1_00000000_0};
    v[2] = '{8'hFF, 8'hFF, 10'b1_11111111_0};
    v[3] = '{8'hC3, 8'h3C, 10'b1_11000011_0};
    v[4] = '{8'h5A, 8'hFF, 10'b1_01011010_0};
    v[5] = '{8'h01, 8'h00, 10'b1_00000001_0};
    v[6] = '{8'h80, 8'h7F, 10'b1_10000000_0};
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tvalid2 = 1'b0; tdata2 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_line", 32'(tx_data), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0; dn = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (!tx_data || busy || !tready) bad++;
      if (done) dn++;
    end
    chk("idle_state", 32'(bad), 32'd0);
    chk("idle_no_done", 32'(dn), 32'd0);

    for (int i = 0; i < 7; i++) run_frame(v[i], $sformatf("vec%0d", i));

    // Back-to-back: tvalid held across the tx_done cycle.
    n0 = rx_n;
    wait_ready("b2b");
    tvalid = 1'b1;
    tdata  = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    tdata = 8'hFF;
    kd = -1; ka = -1; pb = 1'b1;
    for (int k = 1; k <= 3 * N * 10 && ka < 0; k++) begin
      @(posedge clk); #1;
      if (done && kd < 0) kd = k;
      if (busy && !pb) ka = k;
      pb = busy;
    end
    @(negedge clk);
    tvalid = 1'b0;
    chk("b2b_done_cycle", 32'(kd), 32'(10 * N));
    chk("b2b_second_accept", 32'(ka), 32'(10 * N + 1));
    repeat (10 * N + 5) @(posedge clk);
    #1;
    chk("b2b_rx_count", 32'(rx_n - n0), 32'd2);
    chk("b2b_rx0", 32'(rx_mem[n0]), 32'h100);
    chk("b2b_rx1", 32'(rx_mem[n0 + 1]), 32'h1FF);

    // Reset 1000 cycles into a frame.
    n0 = rx_n;
    wait_ready("rst_mid");
    tvalid = 1'b1;
    tdata  = 8'h96;
    @(posedge clk); #1;
    @(negedge clk);
    tvalid = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("rst_mid_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", 32'(tx_data), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_tready", 32'(tready), 32'd0);
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * N) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("rst_mid_no_done", 32'(dn), 32'd0);
    chk("rst_mid_no_rx", 32'(rx_n - n0), 32'd0);
    run_frame('{8'h3C, 8'h3C, 10'b1_00111100_0}, "post_rst");

    // Two stop bits, 256 random bytes streamed with tvalid held.
    for (int i = 0; i < 256; i++) b[i] = 8'($urandom_range(0, 255));
    n0 = rx2_n;
    @(negedge clk);
    tvalid2 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tdata2 = b[i];
      w = 0;
      while (!tready2 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!tready2) begin
        chk("sb2_ready_timeout", 32'(tready2), 32'd1);
        break;
      end
      @(negedge clk);
      acc[i] = cyc;
    end
    tvalid2 = 1'b0;
    bad = 0;
    for (int i = 1; i < 256; i++) if (acc[i] - acc[i - 1] != 11 * N2 + 1) bad++;
    chk("sb2_period", 32'(bad), 32'd0);
    repeat (20 * N2) @(posedge clk);
    #1;
    chk("sb2_rx_count", 32'(rx2_n - n0), 32'd256);
    for (int i = 0; i < 256; i++)
      chk($sformatf("sb2_rx%0d", i), 32'(rx2_mem[n0 + i]), 32'({1'b1, b[i]}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
